pb_conditioner: RTL and testbench
=================================

PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000 (5 ms at 50 MHz); stable-level cycles required to accept a press or release.
REQ-002 Parameter REPEAT_DELAY, default 25000000 (500 ms); held cycles after the first pulse before auto-repeat starts.
REQ-003 Parameter REPEAT_PERIOD, default 5000000 (100 ms); cycles between auto-repeat pulses.
REQ-004 CLK_50  input  1  single 50 MHz system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn  input  1 each  raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-007 freq_up_pulse, freq_dn_pulse, seq_up_pulse, seq_dn_pulse  output  1 each  registered single-cycle step request to the KROS core.
REQ-008 pb_held  output  4  registered debounced pressed level, bit order {seq_dn, seq_up, freq_dn, freq_up}.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer and be inverted to an active-high pressed_s before any other use.
REQ-010 Each button SHALL run an independent FSM: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT, with one shared-width cycle counter per channel.
REQ-011 IDLE: pressed_s=1 -> PRESS_WAIT, counter cleared.
REQ-012 PRESS_WAIT: pressed_s=0 -> IDLE with no pulse; DEBOUNCE_CYCLES consecutive pressed samples -> HELD, emitting one pulse.
REQ-013 HELD: pressed_s=0 -> RELEASE_WAIT; REPEAT_DELAY cycles held -> REPEAT, emitting one pulse.
REQ-014 REPEAT: one pulse every REPEAT_PERIOD cycles while pressed; pressed_s=0 -> RELEASE_WAIT.
REQ-015 RELEASE_WAIT: pressed_s=1 -> HELD, counter cleared, no pulse (release bounce); DEBOUNCE_CYCLES consecutive released samples -> IDLE.
REQ-016 The first pulse SHALL be high exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the input low, for a clean press.
REQ-017 Every pulse SHALL be exactly one cycle wide; pulses on one channel SHALL never be consecutive.
REQ-018 pb_held bit SHALL be 1 in HELD, REPEAT and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-019 Counters SHALL saturate; they SHALL never wrap within a state.
REQ-020 Counter width SHALL be the clog2 of the largest of the three parameters.
REQ-021 If freq_up and freq_dn would pulse in the same cycle, both SHALL be suppressed for that cycle; the same rule applies to seq_up/seq_dn.
REQ-022 Pulses from different pairs SHALL be independent and may coincide.
REQ-023 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no pb_held change.

Reset
REQ-024 reset=1 SHALL force all FSMs to IDLE, counters to 0, all pulses and pb_held to 0, and synchronizer flops to 1 (released).
REQ-025 Reset asserted mid-press SHALL abort the press with no pulse.
REQ-026 A button held through reset deassertion SHALL require a full debounce and then pulse once.

Structure
REQ-027 The shared package kros_pkg SHALL hold the FSM state encoding, the button-index constants (FREQ_UP=0, FREQ_DN=1, SEQ_UP=2, SEQ_DN=3) and the default timing constants.
REQ-028 Per-button logic (synchronizer, FSM, counter) SHALL be one sub-module, pb_channel, instantiated four times.
REQ-029 The top level SHALL contain only the four instances, the conflict suppression and the output registers.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8)
REQ-030 Clean press: pb_seq_up=0 held 10 cycles, then 1 -> exactly one seq_up_pulse, 7 edges after the press; pb_held[2] high from then until 4 released cycles have passed.
REQ-031 Bounce: pb_freq_up toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> no pulse and pb_held=0 throughout.
REQ-032 Auto-repeat: pb_freq_dn=0 held 60 cycles -> pulses at cycle offsets 7, 23, 31, 39, 47, 55 relative to the press.
REQ-033 Conflict: pb_seq_up and pb_seq_dn pressed on the same edge -> no seq pulses; an independent pb_freq_up press at the same time still pulses at +7.
REQ-034 Reset mid-press: reset=1 at press+5 for 2 cycles with the button still held -> no pulse during reset; one pulse 7 edges after reset deasserts.
REQ-035 Release bounce: after HELD, a 2-cycle release followed by a re-press -> no extra pulse, and the auto-repeat timing restarts from the re-press.

Source files
------------

// File: rtl/pb_conditioner_pkg.sv
// kros_pkg: shared FSM encoding, button indices and default timing for the pushbutton conditioner.
package kros_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } pb_state_t;

    localparam int FREQ_UP = 0;
    localparam int FREQ_DN = 1;
    localparam int SEQ_UP  = 2;
    localparam int SEQ_DN  = 3;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pb_conditioner_if.sv
// pb_conditioner_if: raw active-low buttons in, step pulses and debounced held levels out.
interface pb_conditioner_if;
    logic       pb_freq_up;
    logic       pb_freq_dn;
    logic       pb_seq_up;
    logic       pb_seq_dn;
    logic       freq_up_pulse;
    logic       freq_dn_pulse;
    logic       seq_up_pulse;
    logic       seq_dn_pulse;
    logic [3:0] pb_held;

    modport slave (
        input  pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn,
        output freq_up_pulse, freq_dn_pulse, seq_up_pulse, seq_dn_pulse, pb_held
    );

    modport master (
        output pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn,
        input  freq_up_pulse, freq_dn_pulse, seq_up_pulse, seq_dn_pulse, pb_held
    );
endinterface

// File: rtl/pb_conditioner_channel.sv
// pb_channel: one button's synchronizer, debounce/auto-repeat FSM and saturating counter.
module pb_channel
    import kros_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_n,
    output logic pulse,
    output logic held
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DEB_M1 = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_M1 = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_M1 = CW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          pressed_s;
    pb_state_t     state;

    assign pressed_s = ~sync[1];
    assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;

    // Each "fire" test compares against N-1 because the entry edge already cleared the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            sync  <= {sync[0], pb_n};
            pulse <= 1'b0;
            cnt   <= cnt_inc;
            case (state)
                IDLE: if (pressed_s) begin
                    state <= PRESS_WAIT;
                    cnt   <= '0;
                end
                PRESS_WAIT: if (!pressed_s) begin
                    state <= IDLE;
                end else if (cnt >= DEB_M1) begin
                    state <= HELD;
                    cnt   <= '0;
                    pulse <= 1'b1;
                    held  <= 1'b1;
                end
                HELD: if (!pressed_s) begin
                    state <= RELEASE_WAIT;
                    cnt   <= '0;
                end else if (cnt >= DLY_M1) begin
                    state <= REPEAT;
                    cnt   <= '0;
                    pulse <= 1'b1;
                end
                REPEAT: if (!pressed_s) begin
                    state <= RELEASE_WAIT;
                    cnt   <= '0;
                end else if (cnt >= PER_M1) begin
                    cnt   <= '0;
                    pulse <= 1'b1;
                end
                RELEASE_WAIT: if (pressed_s) begin
                    state <= HELD;
                    cnt   <= '0;
                end else if (cnt >= DEB_M1) begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/pb_conditioner.sv
// pb_conditioner: four debounced pushbutton channels with up/down conflict suppression.
module pb_conditioner
    import kros_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input logic               CLK_50,
    input logic               reset,
    pb_conditioner_if.slave   pb
);
    logic [3:0] raw;
    logic [3:0] p;
    logic [3:0] h;

    assign raw = {pb.pb_seq_dn, pb.pb_seq_up, pb.pb_freq_dn, pb.pb_freq_up};

    genvar i;
    for (i = 0; i < 4; i++) begin : g_ch
        pb_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk  (CLK_50),
            .rst  (reset),
            .pb_n (raw[i]),
            .pulse(p[i]),
            .held (h[i])
        );
    end

    // Opposing steps in the same cycle cancel; the two pairs never interact.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            pb.freq_up_pulse <= 1'b0;
            pb.freq_dn_pulse <= 1'b0;
            pb.seq_up_pulse  <= 1'b0;
            pb.seq_dn_pulse  <= 1'b0;
            pb.pb_held       <= '0;
        end else begin
            pb.freq_up_pulse <= p[FREQ_UP] & ~p[FREQ_DN];
            pb.freq_dn_pulse <= p[FREQ_DN] & ~p[FREQ_UP];
            pb.seq_up_pulse  <= p[SEQ_UP] & ~p[SEQ_DN];
            pb.seq_dn_pulse  <= p[SEQ_DN] & ~p[SEQ_UP];
            pb.pb_held       <= h;
        end
    end
endmodule

// File: tb/tb_pb_conditioner.sv
// tb_pb_conditioner: directed vector table plus hand sequences for bounce, reset and release-bounce.
module tb_pb_conditioner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    pb_conditioner_if pb();

    pb_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (16),
        .REPEAT_PERIOD  (8)
    ) dut (
        .CLK_50(clk),
        .reset (reset),
        .pb    (pb.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  press;
        int          hold;
        int          len;
        logic [3:0]  pmask;
        logic [79:0] pat;
        logic [3:0]  hmask;
    } vec_t;

    vec_t vt[6];

    function automatic logic [79:0] at(input int a, input int b, input int c,
                                       input int d, input int e, input int f);
        logic [79:0] r;
        int l[6];
        r = '0;
        l = '{a, b, c, d, e, f};
        for (int j = 0; j < 6; j++) if (l[j] >= 0) r[l[j]] = 1'b1;
        return r;
    endfunction

    task automatic apply(input logic [3:0] pressed);
        pb.pb_freq_up = ~pressed[0];
        pb.pb_freq_dn = ~pressed[1];
        pb.pb_seq_up  = ~pressed[2];
        pb.pb_seq_dn  = ~pressed[3];
    endtask

    task automatic check(input string name, input int k, input logic [3:0] ep, input logic [3:0] eh);
        logic [3:0] ap;
        ap = {pb.seq_dn_pulse, pb.seq_up_pulse, pb.freq_dn_pulse, pb.freq_up_pulse};
        total++;
        if (ap !== ep || pb.pb_held !== eh) begin
            bad++;
            $display("FAIL %s edge %0d: pulses=%b held=%b, required pulses=%b held=%b",
                     name, k, ap, pb.pb_held, ep, eh);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{"clean_seq_up",  4'b0100, 10, 24, 4'b0100, at(7, -1, -1, -1, -1, -1), 4'b0100};
        vt[1] = '{"repeat_freq_dn", 4'b0010, 60, 75, 4'b0010, at(7, 23, 31, 39, 47, 55), 4'b0010};
        vt[2] = '{"conflict_seq",  4'b1101, 10, 24, 4'b0001, at(7, -1, -1, -1, -1, -1), 4'b1101};
        vt[3] = '{"glitch_4",      4'b0010, 4, 16, 4'b0000, '0, 4'b0000};
        vt[4] = '{"min_press_5",   4'b1000, 5, 16, 4'b1000, at(7, -1, -1, -1, -1, -1), 4'b1000};
        vt[5] = '{"indep_pairs",   4'b0101, 10, 24, 4'b0101, at(7, -1, -1, -1, -1, -1), 4'b0101};

        apply(4'b0000);
        reset = 1'b1;
        repeat (3) tick();
        check("reset_state", 0, 4'b0000, 4'b0000);
        reset = 1'b0;
        repeat (4) tick();
        check("idle_after_reset", 0, 4'b0000, 4'b0000);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < vt[i].len; k++) begin
                apply(k < vt[i].hold ? vt[i].press : 4'b0000);
                tick();
                check(vt[i].name, k, vt[i].pat[k] ? vt[i].pmask : 4'b0000,
                      (k >= 7 && k <= vt[i].hold + 6) ? vt[i].hmask : 4'b0000);
            end
        end

        for (int k = 0; k < 30; k++) begin
            apply((k < 20 && (k / 2) % 2 == 0) ? 4'b0001 : 4'b0000);
            tick();
            check("bounce_freq_up", k, 4'b0000, 4'b0000);
        end

        for (int k = 0; k < 30; k++) begin
            apply(4'b1000);
            reset = (k == 5 || k == 6);
            tick();
            check("reset_mid_press", k, k == 14 ? 4'b1000 : 4'b0000, k >= 14 ? 4'b1000 : 4'b0000);
        end
        reset = 1'b0;
        apply(4'b0000);
        repeat (12) tick();

        for (int k = 0; k < 52; k++) begin
            apply((k < 40 && k != 10 && k != 11) ? 4'b0100 : 4'b0000);
            tick();
            check("release_bounce", k, (k == 7 || k == 31 || k == 39) ? 4'b0100 : 4'b0000,
                  (k >= 7 && k <= 46) ? 4'b0100 : 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
